// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the convolution datapath:
// default Q2.30 format, its saturation limits, the accumulator FSM
// state type and a Q2.30 saturate helper for any stage that holds a
// wider signed intermediate.
package fxp_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int FRAC_SIZE_DEF = 30;

    localparam logic [31:0] Q2_30_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q2_30_MIN = 32'h8000_0000;

    localparam logic signed [63:0] Q2_30_LIM_HI = 64'sd2147483647;
    localparam logic signed [63:0] Q2_30_LIM_LO = -64'sd2147483648;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Clamp a sign-extended 64-bit intermediate into Q2.30.
    function automatic logic [31:0] saturate_q2_30(input logic signed [63:0] val);
        logic [31:0] res;
        if (val > Q2_30_LIM_HI) begin
            res = Q2_30_MAX;
        end else if (val < Q2_30_LIM_LO) begin
            res = Q2_30_MIN;
        end else begin
            res = val[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp_saturate.sv
// Combinational clamp from a WIDTH+GUARD signed accumulator down to a
// WIDTH signed result. The value fits only when all guard bits and the
// result sign bit agree; otherwise it is pinned to MAX or MIN by the
// accumulator sign.
module fxp_saturate
    import fxp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GUARD = 8
) (
    input  logic signed [WIDTH+GUARD-1:0] acc,
    output logic signed [WIDTH-1:0]       sat
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [GUARD:0] hi_bits;

    assign hi_bits = acc[ACC_W-1:WIDTH-1];

    // Pass the low bits through unless the upper bits are not a pure sign extension
    always_comb begin
        sat = acc[WIDTH-1:0];
        if (hi_bits != {(GUARD+1){acc[ACC_W-1]}}) begin
            sat = acc[ACC_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Window accumulator: sums bias plus LEN signed Q2.30 products in a
// WIDTH+GUARD accumulator, saturates once at the end of the window and
// holds the result on a valid/ready output until it is taken. Input is
// stalled (in_ready low) while a result is held.
// Optional build macro FXP_ACC_RELU_EN: clamp negative results to zero
// after saturation.
module fixed_point_accumulator
    import fxp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAC_SIZE = FRAC_SIZE_DEF,
    parameter int LEN       = 25,
    parameter int GUARD     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] bias,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    if (LEN < 1 || LEN > 255 || FRAC_SIZE >= WIDTH || GUARD < 1) begin : g_bad_params
        $error("fixed_point_accumulator: illegal LEN/FRAC_SIZE/GUARD");
    end

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] sat_val;
    logic signed [WIDTH-1:0] res_val;
    logic                    last_beat;

    // in_ready depends on state only, never on out_ready
    assign in_ready  = (state_q != DONE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Accumulator value after a beat: a window starts from bias, later beats add to ACC
    always_comb begin
        if (state_q == IDLE) begin
            acc_sum = {{GUARD{bias[WIDTH-1]}}, bias}
                    + {{GUARD{in_data[WIDTH-1]}}, in_data};
        end else begin
            acc_sum = acc_q + {{GUARD{in_data[WIDTH-1]}}, in_data};
        end
    end

    fxp_saturate #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) u_sat (
        .acc (acc_sum),
        .sat (sat_val)
    );

    // Optional ReLU on the already saturated window result
    always_comb begin
`ifdef FXP_ACC_RELU_EN
        res_val = sat_val[WIDTH-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    // Flags the beat that completes the window
    always_comb begin
        last_beat = 1'b0;
        if (state_q == IDLE) begin
            last_beat = (LEN == 1);
        end else if (state_q == ACCUM) begin
            last_beat = (count_q == LAST_CNT);
        end
    end

    // Next-state logic; clear overrides any beat or output handshake
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = IDLE;
            count_d     = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_d   = acc_sum;
                        count_d = (state_q == IDLE) ? CNT_W'(1) : count_q + 1'b1;
                        if (last_beat) begin
                            state_d     = DONE;
                            out_data_d  = res_val;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        count_d     = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    count_d     = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, counter, accumulator and registered output; reset discards everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator with LEN = 4. Directed scenarios
// (reset, sign, saturation, backpressure, gaps, clear) followed by
// random windows, all compared against a plain-arithmetic window model.
`timescale 1ns/1ps
module tb_fixed_point_accumulator;

    localparam int WIDTH = 32;
    localparam int LEN   = 4;
    localparam int GUARD = 8;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  bias = '0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] p [4];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    fixed_point_accumulator #(
        .WIDTH     (WIDTH),
        .FRAC_SIZE (30),
        .LEN       (LEN),
        .GUARD     (GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bias      (bias),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact sum of bias and products, clamped to Q2.30
    function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] pr [4]);
        longint sum;
        logic [31:0] r;
        sum = longint'($signed(b));
        for (int i = 0; i < 4; i++) sum += longint'($signed(pr[i]));
        if (sum > MAXV)      r = 32'h7FFF_FFFF;
        else if (sum < MINV) r = 32'h8000_0000;
        else                 r = sum[31:0];
`ifdef FXP_ACC_RELU_EN
        if (r[31]) r = 32'h0;
`endif
        return r;
    endfunction

    // One full window: optional idle gaps before beats, then stall cycles on the output
    task automatic do_window(input string tag, input logic [31:0] b, input logic [31:0] pr [4],
                             input logic [3:0] gaps, input int stall);
        logic [31:0] e;
        e = model(b, pr);
        for (int i = 0; i < 4; i++) begin
            if (gaps[i]) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
                check({tag, "_gap_valid"}, {31'b0, out_valid}, 32'd0);
            end
            check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = pr[i];
            if (i == 0) bias = b;
            tick();
            bias = $urandom;
            if (i < 3) check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, e);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
            check({tag, "_stall_ready"}, {31'b0, in_ready}, 32'd0);
            check({tag, "_stall_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_stall_data"}, out_data, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_post_data"}, out_data, e);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'h3000_0000 + ($urandom & 32'h0FFF_FFFF);
            2: v = 32'hC000_0000 - ($urandom & 32'h0FFF_FFFF);
            default: v = {{8{1'b0}}, 24'($urandom)} - 32'h0080_0000;
        endcase
        return v;
    endfunction

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("rel_ready", {31'b0, in_ready}, 32'd1);

        // Sign handling: 0.25 + 4 * -0.125 = -0.25
        p = '{32'hF800_0000, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000};
        do_window("neg_quarter", 32'h1000_0000, p, 4'b0000, 0);
`ifdef FXP_ACC_RELU_EN
        check("neg_quarter_abs", out_data, 32'h0000_0000);
`else
        check("neg_quarter_abs", out_data, 32'hF000_0000);
`endif

        // Positive and negative saturation
        p = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
        do_window("sat_pos", 32'h0, p, 4'b0000, 0);
        check("sat_pos_abs", out_data, 32'h7FFF_FFFF);
        p = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};
        do_window("sat_neg", 32'h0, p, 4'b0000, 0);
`ifdef FXP_ACC_RELU_EN
        check("sat_neg_abs", out_data, 32'h0000_0000);
`else
        check("sat_neg_abs", out_data, 32'h8000_0000);
`endif

        // Backpressure for 5 cycles, then a normal window right after
        p = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
        do_window("stall5", 32'h0010_0000, p, 4'b0000, 5);
        p = '{32'h0123_4567, 32'hFEDC_BA98, 32'h0800_0000, 32'h0000_0001};
        do_window("after_stall", 32'h0000_0100, p, 4'b0000, 0);

        // Gapped window gives the gapless result
        do_window("gapped", 32'h0000_0100, p, 4'b1010, 1);

        // Clear after 2 beats: no output, next window ignores aborted beats
        in_valid = 1'b1;
        bias     = 32'h1111_1111;
        in_data  = 32'h2222_2222;
        tick();
        tick();
        clear    = 1'b1;
        in_data  = 32'h3333_3333;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", {31'b0, out_valid}, 32'd0);
        check("clr_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("clr_idle_valid", {31'b0, out_valid}, 32'd0);
        p = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
        do_window("post_clear", 32'h0000_0005, p, 4'b0000, 0);

        // Clear while a result is held drops out_valid
        in_valid = 1'b1;
        bias     = 32'h0;
        in_data  = 32'h0000_0010;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_done_valid", {31'b0, out_valid}, 32'd0);
        check("clr_done_ready", {31'b0, in_ready}, 32'd1);

        // Random windows
        for (int w = 0; w < 16; w++) begin
            logic [31:0] b;
            for (int i = 0; i < 4; i++) p[i] = rand_val();
            b = rand_val();
            do_window($sformatf("rand%0d", w), b, p, 4'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a window discards everything
        exp_v = out_data;
        in_valid = 1'b1;
        bias     = 32'h0400_0000;
        in_data  = 32'h0100_0000;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        tick();
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("mid_rel_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rel_valid", {31'b0, out_valid}, 32'd0);
        p = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        do_window("after_rst", 32'h0000_0010, p, 4'b0000, 0);
        check("after_rst_abs", out_data, 32'h0000_001A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fixed_point_accumulator.md
# fixed_point_accumulator

Streaming multiply-accumulate back end that consumes the signed Q2.30 products of the fixed-point multiplier and sums one kernel window (LEN terms) plus a bias into a single saturated Q2.30 result. It sits directly downstream of the multiplier in the convolution datapath and feeds the activation/pooling stage through a valid/ready handshake. It holds one result and stalls its input until that result is accepted.

## Interface
- WIDTH, 32, data width of products, bias and result (signed, two's complement)
- FRAC_SIZE, 30, fractional bits; format is Q(WIDTH-FRAC_SIZE).FRAC_SIZE
- LEN, 25, products per window (5x5 kernel); legal range 1..255
- GUARD, 8, extra integer guard bits in the internal accumulator
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort: drop partial sum, return to IDLE
- bias  input  WIDTH  signed bias, sampled with the first beat of a window
- in_data  input  WIDTH  signed product from the multiplier
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  WIDTH  saturated window result
- out_valid  output  1  out_data valid, held until accepted
- out_ready  input  1  downstream accepts out_data

## Operation
- States: IDLE (no beats taken), ACCUM (1..LEN-1 beats taken), DONE (result held).
- Beat = in_valid & in_ready. in_ready = 1 in IDLE/ACCUM, 0 in DONE.
- Accumulator ACC is WIDTH+GUARD bits signed; operands sign-extended, no intermediate saturation.
- Beat in IDLE: ACC <= sext(bias) + sext(in_data), count <= 1; go to ACCUM, or straight to DONE if LEN == 1.
- Beat in ACCUM: ACC <= ACC + sext(in_data), count <= count + 1; on the LEN-th beat go to DONE.
- On entry to DONE: out_data <= sat(next ACC), out_valid <= 1.
- sat(): if ACC > 2^(WIDTH-1)-1, the result is 0x7FFFFFFF. If ACC < -2^(WIDTH-1), the result is 0x80000000. Otherwise the result is the low WIDTH bits. Binary point is unchanged; no rescaling.
- DONE with out_ready = 1: out_valid <= 0, go to IDLE. out_data keeps its last value.
- in_valid low in any state: no state change, partial sum retained indefinitely.
- clear = 1: next cycle IDLE, count = 0, ACC = 0, out_valid = 0; it overrides a beat or output handshake in the same cycle.
- Reset mid-window or mid-handoff: all state is discarded with no partial output.

## Timing
- Reset values: state IDLE, count 0, ACC 0, out_data 0, out_valid 0; in_ready 1 once rst_n is released.
- Throughput: 1 beat/cycle inside a window.
- Latency: out_valid rises the cycle after the LEN-th beat.
- Minimum window period is LEN+1 cycles. The cycle after the output handshake is IDLE with in_ready = 1, so there is one bubble per window.
- out_data and out_valid are registered. in_ready is a function of state only and has no combinational path from out_ready.
- out_data is stable while out_valid = 1 and out_ready = 0.

## Configuration
- FXP_ACC_RELU_EN defined: ReLU is applied after saturation, so a negative sat(ACC) gives out_data = 0.
- FXP_ACC_RELU_EN undefined: out_data = sat(ACC), signed, unchanged.
- The macro has no effect on timing or on the interface.

## Structure
- Shared package fxp_pkg holds:
  - WIDTH/FRAC_SIZE defaults and the Q2.30 MAX/MIN constants (0x7FFFFFFF, 0x80000000)
  - the state enum {IDLE, ACCUM, DONE}
  - a saturate function, also reused by the multiplier and later stages
- One sub-module is natural: fxp_saturate (WIDTH+GUARD to WIDTH clamp, combinational). The FSM, counter and accumulator stay in the top.

## Test plan
- Reset: hold rst_n = 0 mid-window, release → out_valid = 0, out_data = 0, in_ready = 1, and the next window starts fresh from bias.
- LEN = 4, bias 0x10000000 (0.25), four products 0xF8000000 (-0.125) back to back, out_ready = 1 → out_data = 0xF0000000 (-0.25), out_valid one cycle after the 4th beat.
- Same stimulus with FXP_ACC_RELU_EN defined → out_data = 0x00000000.
- Positive saturation: LEN = 4, bias 0, four products 0x20000000 (0.5) sum to 2.0 → out_data = 0x7FFFFFFF. Negative: four products 0xC0000000 (-1.0) → 0x80000000.
- Backpressure: out_ready = 0 for 5 cycles after out_valid → in_ready = 0, out_data stable, in_valid pulses ignored. Raise out_ready → IDLE next cycle, and the following window result is correct.
- Gaps and clear: in_valid toggling 1,0,1,0 inside a window → same result as the gapless case. clear asserted after 2 of 4 beats → no output, and the next 4-beat window excludes the aborted beats.
